axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave.sv | 165 ++++++++++++++++
 tb/tb_axi_ram_slave.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI4 burst slave backed by a single-port synchronous word RAM
// One transaction at a time; writes win over reads; reads take two cycles per beat.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif

module axi_ram_slave #(
  parameter int ADDR_W     = `DDR_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awid,
  input  logic [2:0]          axi_awsize,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic [3:0]          axi_awqos,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arid,
  input  logic [2:0]          axi_arsize,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic [3:0]          axi_arqos,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem [0:(1 << MEM_ADDR_W) - 1];
  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_ADDR_W-1:0] next_addr;
  logic [7:0]            cnt;
  logic [1:0]            burst;
  logic                  werr;
  logic                  aw_rdy;
  logic                  mem_we;
  logic                  unused_ok;

  assign unused_ok = ^{axi_awid, axi_awsize, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                       axi_arid, axi_arsize, axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                       axi_awaddr, axi_araddr};

  assign axi_awready = aw_rdy;
  assign axi_arready = aw_rdy & ~axi_awvalid;
  assign mem_we      = axi_wready & axi_wvalid;
  // WRAP and reserved bursts step like INCR; only FIXED holds the address
  assign next_addr   = (burst == 2'b00) ? addr : addr + 1'b1;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_wstrb[b]) mem[addr][b*8 +: 8] <= axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      aw_rdy     <= 1'b0;
      axi_wready <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= 2'b00;
      axi_rvalid <= 1'b0;
      axi_rlast  <= 1'b0;
      axi_rresp  <= 2'b00;
      axi_rdata  <= '0;
      addr       <= '0;
      cnt        <= 8'd0;
      burst      <= 2'b00;
      werr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aw_rdy <= 1'b1;
          if (aw_rdy && axi_awvalid) begin
            addr       <= axi_awaddr[MEM_ADDR_W+1:2];
            cnt        <= axi_awlen;
            burst      <= axi_awburst;
            werr       <= axi_awburst[1];
            aw_rdy     <= 1'b0;
            axi_wready <= 1'b1;
            state      <= WDATA;
          end else if (aw_rdy && axi_arvalid) begin
            addr   <= axi_araddr[MEM_ADDR_W+1:2];
            cnt    <= axi_arlen;
            burst  <= axi_arburst;
            aw_rdy <= 1'b0;
            state  <= RFETCH;
          end
        end
        WDATA: begin
          if (axi_wvalid) begin
            if (axi_wlast != (cnt == 8'd0)) werr <= 1'b1;
            if (cnt == 8'd0) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= (werr || !axi_wlast) ? 2'b10 : 2'b00;
              state      <= WRESP;
            end else begin
              cnt  <= cnt - 8'd1;
              addr <= next_addr;
            end
          end
        end
        WRESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            axi_bresp  <= 2'b00;
            aw_rdy     <= 1'b1;
            state      <= IDLE;
          end
        end
        RFETCH: begin
          axi_rdata  <= mem[addr];
          axi_rvalid <= 1'b1;
          axi_rlast  <= (cnt == 8'd0);
          axi_rresp  <= burst[1] ? 2'b10 : 2'b00;
          state      <= RDATA;
        end
        RDATA: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            if (axi_rlast) begin
              axi_rlast <= 1'b0;
              aw_rdy    <= 1'b1;
              state     <= IDLE;
            end else begin
              addr  <= next_addr;
              cnt   <= cnt - 8'd1;
              state <= RFETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - self-checking bench for axi_ram_slave
// Directed scenarios plus randomized bursts checked against an associative-array memory model.
module tb_axi_ram_slave;
  localparam int DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic [7:0]  axi_awlen = '0;
  logic [1:0]  axi_awburst = '0;
  logic        axi_awid = 1'b0;
  logic [2:0]  axi_awsize = '0;
  logic        axi_awlock = 1'b0;
  logic [3:0]  axi_awcache = '0;
  logic [2:0]  axi_awprot = '0;
  logic [3:0]  axi_awqos = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wlast = 1'b0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic [7:0]  axi_arlen = '0;
  logic [1:0]  axi_arburst = '0;
  logic        axi_arid = 1'b0;
  logic [2:0]  axi_arsize = '0;
  logic        axi_arlock = 1'b0;
  logic [3:0]  axi_arcache = '0;
  logic [2:0]  axi_arprot = '0;
  logic [3:0]  axi_arqos = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int ar_hs_cnt = 0;

  logic [31:0] model [int];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] rd_data[$];
  logic [1:0]  rd_resp[$];
  logic        rd_last[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && axi_arvalid && axi_arready) ar_hs_cnt++;

  axi_ram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
    .axi_awid(axi_awid), .axi_awsize(axi_awsize), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid), .axi_arsize(axi_arsize), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  function automatic int beat_word(input int base, input int i, input logic [1:0] bt);
    return (bt == 2'b00) ? base : (base + i) % DEPTH;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    return model.exists(w) ? model[w] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    for (int i = 0; i <= int'(len); i++) begin
      int w;
      logic [31:0] v;
      w = beat_word(int'(a[17:2]), i, bt);
      v = model_read(w);
      for (int b = 0; b < 4; b++) if (ws_q[i][b]) v[b*8 +: 8] = wd_q[i][b*8 +: 8];
      model[w] = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    int cyc = 0;
    bit hs = 0;
    axi_awaddr = a; axi_awlen = len; axi_awburst = bt;
    axi_awid = 1'($urandom); axi_awsize = 3'($urandom); axi_awlock = 1'($urandom);
    axi_awcache = 4'($urandom); axi_awprot = 3'($urandom); axi_awqos = 4'($urandom);
    axi_awvalid = 1'b1;
    while (!hs && cyc < 50) begin #2; hs = axi_awready; step(); cyc++; end
    axi_awvalid = 1'b0;
    if (!hs) begin tests_run++; tests_failed++; $display("FAIL aw_timeout awready=0 required=1"); end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    int cyc = 0;
    bit hs = 0;
    axi_araddr = a; axi_arlen = len; axi_arburst = bt;
    axi_arid = 1'($urandom); axi_arsize = 3'($urandom); axi_arlock = 1'($urandom);
    axi_arcache = 4'($urandom); axi_arprot = 3'($urandom); axi_arqos = 4'($urandom);
    axi_arvalid = 1'b1;
    while (!hs && cyc < 50) begin #2; hs = axi_arready; step(); cyc++; end
    axi_arvalid = 1'b0;
    if (!hs) begin tests_run++; tests_failed++; $display("FAIL ar_timeout arready=0 required=1"); end
  endtask

  task automatic w_send(input int last_beat, input bit gaps);
    int cyc = 0;
    for (int i = 0; i < wd_q.size(); i++) begin
      bit hs = 0;
      if (gaps) while ($urandom_range(0, 3) == 0) step();
      axi_wdata = wd_q[i]; axi_wstrb = ws_q[i]; axi_wlast = (i == last_beat); axi_wvalid = 1'b1;
      while (!hs && cyc < 500) begin #2; hs = axi_wready; step(); cyc++; end
      axi_wvalid = 1'b0; axi_wlast = 1'b0;
      if (!hs) begin
        tests_run++; tests_failed++;
        $display("FAIL w_timeout beat=%0d wready=0 required=1", i);
        return;
      end
    end
  endtask

  task automatic b_recv(output logic [1:0] resp, input bit delay);
    int cyc = 0;
    bit hs = 0;
    resp = 2'bxx;
    if (delay) repeat ($urandom_range(0, 3)) step();
    axi_bready = 1'b1;
    while (!hs && cyc < 50) begin
      #2;
      if (axi_bvalid) begin hs = 1; resp = axi_bresp; end
      step(); cyc++;
    end
    axi_bready = 1'b0;
    if (!hs) begin tests_run++; tests_failed++; $display("FAIL b_timeout bvalid=0 required=1"); end
  endtask

  task automatic r_recv(input int n, input bit rnd);
    int cyc = 0;
    rd_data.delete(); rd_resp.delete(); rd_last.delete();
    while (rd_data.size() < n && cyc < 1000) begin
      axi_rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #2;
      if (axi_rvalid && axi_rready) begin
        rd_data.push_back(axi_rdata); rd_resp.push_back(axi_rresp); rd_last.push_back(axi_rlast);
      end
      step(); cyc++;
    end
    axi_rready = 1'b0;
    if (rd_data.size() < n) begin
      tests_run++; tests_failed++;
      $display("FAIL r_timeout beats=%0d required=%0d", rd_data.size(), n);
      while (rd_data.size() < n) begin
        rd_data.push_back('x); rd_resp.push_back('x); rd_last.push_back(1'bx);
      end
    end
  endtask

  task automatic fill(input int n, input bit rnd_strb);
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < n; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(rnd_strb ? 4'($urandom) : 4'hF);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags aw/ar/w/b/r/last=%b required=000000",
               {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast});
    end
    tests_run++;
    if ({axi_bresp, axi_rresp, axi_rdata} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_data bresp=%b rresp=%b rdata=%h required 0", axi_bresp, axi_rresp, axi_rdata);
    end
    rst = 1'b1;
    #2;
    tests_run++;
    if (axi_awready !== 1'b0) begin tests_failed++; $display("FAIL release_pre_edge awready=%b required=0", axi_awready); end
    step();
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b11) begin
      tests_failed++; $display("FAIL idle_ready aw/ar=%b required=11", {axi_awready, axi_arready});
    end
    axi_awvalid = 1'b1;
    #1;
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b10) begin
      tests_failed++; $display("FAIL idle_arready_gate aw/ar=%b required=10", {axi_awready, axi_arready});
    end
    axi_awvalid = 1'b0;
    step();
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp;
    wd_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    aw_send(32'h100, 8'd3, 2'b01); w_send(3, 0); b_recv(resp, 0);
    model_write(32'h100, 8'd3, 2'b01);
    tests_run++;
    if (resp !== 2'b00) begin tests_failed++; $display("FAIL incr_bresp bresp=%b required=00", resp); end
    ar_send(32'h100, 8'd3, 2'b01); r_recv(4, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00) begin
        tests_failed++;
        $display("FAIL incr_read beat=%0d data=%h last=%b resp=%b required data=%h last=%b resp=00",
                 i, rd_data[i], rd_last[i], rd_resp[i], i + 1, i == 3);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    wd_q = '{32'hAABBCCDD}; ws_q = '{4'hF};
    aw_send(32'h0, 8'd0, 2'b01); w_send(0, 0); b_recv(resp, 0);
    model_write(32'h0, 8'd0, 2'b01);
    wd_q = '{32'h11223344}; ws_q = '{4'h5};
    aw_send(32'h0, 8'd0, 2'b01); w_send(0, 0); b_recv(resp, 0);
    model_write(32'h0, 8'd0, 2'b01);
    ar_send(32'h0, 8'd0, 2'b01); r_recv(1, 0);
    tests_run++;
    if (rd_data[0] !== 32'hAA22CC44 || rd_last[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL strobe_merge data=%h last=%b required data=aa22cc44 last=1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_priority();
    logic [1:0] resp;
    int hs_before;
    axi_araddr = 32'h100; axi_arlen = 8'd0; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    axi_awaddr = 32'h200; axi_awvalid = 1'b1;
    #2;
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b10) begin
      tests_failed++; $display("FAIL prio_ready aw/ar=%b required=10", {axi_awready, axi_arready});
    end
    hs_before = ar_hs_cnt;
    fill(1, 0);
    aw_send(32'h200, 8'd0, 2'b01); w_send(0, 0); b_recv(resp, 0);
    model_write(32'h200, 8'd0, 2'b01);
    tests_run++;
    if (ar_hs_cnt !== hs_before) begin
      tests_failed++; $display("FAIL prio_no_early_ar handshakes=%0d required=%0d", ar_hs_cnt, hs_before);
    end
    #1;
    tests_run++;
    if (axi_arready !== 1'b1) begin tests_failed++; $display("FAIL prio_ar_after_b arready=%b required=1", axi_arready); end
    ar_send(32'h100, 8'd0, 2'b01); r_recv(1, 0);
    tests_run++;
    if (rd_data[0] !== model_read(32'h40)) begin
      tests_failed++; $display("FAIL prio_read data=%h required=%h", rd_data[0], model_read(32'h40));
    end
  endtask

  task automatic test_wlast_fixed();
    logic [1:0] resp;
    fill(2, 0);
    aw_send(32'h8, 8'd1, 2'b01); w_send(0, 0); b_recv(resp, 0);
    model_write(32'h8, 8'd1, 2'b01);
    tests_run++;
    if (resp !== 2'b10) begin tests_failed++; $display("FAIL early_wlast_bresp bresp=%b required=10", resp); end
    ar_send(32'h8, 8'd2, 2'b00); r_recv(3, 0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rd_data[i] !== wd_q[0] || rd_last[i] !== (i == 2) || rd_resp[i] !== 2'b00) begin
        tests_failed++;
        $display("FAIL fixed_read beat=%0d data=%h last=%b resp=%b required data=%h last=%b resp=00",
                 i, rd_data[i], rd_last[i], rd_resp[i], wd_q[0], i == 2);
      end
    end
    ar_send(32'hC, 8'd0, 2'b01); r_recv(1, 0);
    tests_run++;
    if (rd_data[0] !== wd_q[1]) begin tests_failed++; $display("FAIL second_word data=%h required=%h", rd_data[0], wd_q[1]); end
  endtask

  task automatic test_stall_reset();
    int cyc = 0;
    logic [31:0] d0;
    logic l0;
    ar_send(32'h100, 8'd3, 2'b01);
    axi_rready = 1'b0;
    #2;
    while (!axi_rvalid && cyc < 20) begin step(); #2; cyc++; end
    d0 = axi_rdata; l0 = axi_rlast;
    tests_run++;
    if (axi_rvalid !== 1'b1 || d0 !== model_read(32'h40) || l0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_first rvalid=%b data=%h last=%b required 1 %h 0", axi_rvalid, d0, l0, model_read(32'h40));
    end
    for (int k = 0; k < 5; k++) begin
      step(); #2;
      tests_run++;
      if (axi_rvalid !== 1'b1 || axi_rdata !== d0 || axi_rlast !== l0) begin
        tests_failed++;
        $display("FAIL stall_hold cycle=%0d rvalid=%b data=%h last=%b required 1 %h %b", k, axi_rvalid, axi_rdata, axi_rlast, d0, l0);
      end
    end
    r_recv(4, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data[i] !== model_read(32'h40 + i) || rd_last[i] !== (i == 3)) begin
        tests_failed++;
        $display("FAIL stall_read beat=%0d data=%h last=%b required %h %b", i, rd_data[i], rd_last[i], model_read(32'h40 + i), i == 3);
      end
    end
    ar_send(32'h100, 8'd3, 2'b01); r_recv(2, 0);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({axi_rvalid, axi_rlast, axi_awready} !== 3'b000) begin
      tests_failed++; $display("FAIL async_reset rvalid/rlast/awready=%b required=000", {axi_rvalid, axi_rlast, axi_awready});
    end
    step();
    rst = 1'b1;
    step();
    ar_send(32'h104, 8'd1, 2'b01); r_recv(2, 0);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (rd_data[i] !== model_read(32'h41 + i) || rd_last[i] !== (i == 1)) begin
        tests_failed++;
        $display("FAIL post_reset_read beat=%0d data=%h last=%b required %h %b", i, rd_data[i], rd_last[i], model_read(32'h41 + i), i == 1);
      end
    end
  endtask

  task automatic test_depth_wrap();
    logic [1:0] resp;
    fill(2, 0);
    aw_send(32'hA5C3FFFC, 8'd1, 2'b01); w_send(1, 0); b_recv(resp, 0);
    model_write(32'hA5C3FFFC, 8'd1, 2'b01);
    tests_run++;
    if (resp !== 2'b00) begin tests_failed++; $display("FAIL wrap_bresp bresp=%b required=00", resp); end
    ar_send(32'h0, 8'd0, 2'b01); r_recv(1, 0);
    tests_run++;
    if (rd_data[0] !== wd_q[1]) begin tests_failed++; $display("FAIL depth_wrap word0=%h required=%h", rd_data[0], wd_q[1]); end
    ar_send(32'h0003FFFE, 8'd1, 2'b10); r_recv(2, 0);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (rd_data[i] !== wd_q[i] || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 1)) begin
        tests_failed++;
        $display("FAIL wrap_type_read beat=%0d data=%h resp=%b last=%b required %h 10 %b", i, rd_data[i], rd_resp[i], rd_last[i], wd_q[i], i == 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    logic [1:0] bts [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
    fill(32, 0);
    aw_send(32'h0003FFC0, 8'd31, 2'b01); w_send(31, 0); b_recv(resp, 0);
    model_write(32'h0003FFC0, 8'd31, 2'b01);
    tests_run++;
    if (resp !== 2'b00) begin tests_failed++; $display("FAIL region_fill bresp=%b required=00", resp); end
    for (int t = 0; t < 40; t++) begin
      int w, last_beat;
      logic [7:0] len;
      logic [1:0] bt;
      logic [31:0] a;
      w = (16'hFFF0 + $urandom_range(0, 24)) % DEPTH;
      len = 8'($urandom_range(0, 7));
      bt = bts[$urandom_range(0, 5)];
      a = ($urandom & 32'hFFFC0000) | 32'(w << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        logic [1:0] exp;
        fill(int'(len) + 1, 1);
        last_beat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
        exp = (bt[1] || last_beat != int'(len)) ? 2'b10 : 2'b00;
        aw_send(a, len, bt); w_send(last_beat, 1); b_recv(resp, 1);
        model_write(a, len, bt);
        tests_run++;
        if (resp !== exp) begin
          tests_failed++; $display("FAIL rand_bresp t=%0d bresp=%b required=%b", t, resp, exp);
        end
      end else begin
        ar_send(a, len, bt); r_recv(int'(len) + 1, 1);
        for (int i = 0; i <= int'(len); i++) begin
          logic [31:0] e;
          e = model_read(beat_word(w, i, bt));
          tests_run++;
          if (rd_data[i] !== e || rd_resp[i] !== (bt[1] ? 2'b10 : 2'b00) || rd_last[i] !== (i == int'(len))) begin
            tests_failed++;
            $display("FAIL rand_read t=%0d beat=%0d data=%h resp=%b last=%b required %h %b %b",
                     t, i, rd_data[i], rd_resp[i], rd_last[i], e, bt[1] ? 2'b10 : 2'b00, i == int'(len));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr_burst();
    test_strobe();
    test_priority();
    test_wlast_fixed();
    test_stall_reset();
    test_depth_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish required=finish");
    $fatal(1);
  end
endmodule
